uart_tx_arbiter: RTL

- Shares one uart transmitter (tx_en / tx_data / tx_busy interface) between NUM_REQ byte producers, e.g. ROM string printer, rx echo, status reporter.
- Round-robin arbitration per byte.
- Owns the tx_en pulse handshake with the uart: raise, hold until tx_busy seen, drop, wait for tx_busy low.
- Start-timeout protection so a stuck uart cannot hang producers.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arbiter_rr_pick.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encodings and byte constants.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority picker: first set request strictly after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  // Two passes: indices above ptr first, then the wrapped range 0..ptr.
  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (j > 32'(ptr))) begin
        winner = ID_W'(j);
        any    = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!any && req[j] && (j <= 32'(ptr))) begin
        winner = ID_W'(j);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between NUM_REQ byte producers, with start timeout.
// Optional line lock (no interleaving of text lines) enabled by UART_TX_ARB_LINE_LOCK_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ID_W          = 2,
  parameter int unsigned START_TIMEOUT = 1024,
  parameter int unsigned LOCK_IDLE     = 30000000
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      uart_tx_en,
  output logic [BYTE_W-1:0]         uart_tx_data,
  input  logic                      uart_tx_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      arb_busy,
  output logic                      tx_timeout
);

  localparam int unsigned         CNT_W    = $clog2(START_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [ID_W-1:0]     PTR_RST  = ID_W'(NUM_REQ - 1);

  arb_state_t         r_state, w_state_nxt;
  logic [ID_W-1:0]    r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_tx_en, w_tx_en_nxt;
  logic [BYTE_W-1:0]  r_tx_data, w_tx_data_nxt;
  logic [NUM_REQ-1:0] r_ready, w_ready_nxt;
  logic [ID_W-1:0]    r_grant, w_grant_nxt;
  logic               r_timeout, w_timeout_nxt;

  logic [NUM_REQ-1:0] w_req_eff;
  logic [ID_W-1:0]    w_win;
  logic               w_any;
  logic [NUM_REQ-1:0] w_win_onehot;
  logic [BYTE_W-1:0]  w_sel_data;
  logic               w_accept;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_pick (
    .req    (w_req_eff),
    .ptr    (r_ptr),
    .winner (w_win),
    .any    (w_any)
  );

  always_comb begin
    w_win_onehot = '0;
    w_sel_data   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_win == ID_W'(i)) begin
        w_win_onehot[i] = 1'b1;
        w_sel_data      = req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

`ifdef UART_TX_ARB_LINE_LOCK_EN
  localparam int unsigned       LK_W    = $clog2(LOCK_IDLE) + 1;
  localparam logic [LK_W-1:0]   LK_LAST = LK_W'(LOCK_IDLE - 1);

  logic               r_locked;
  logic [ID_W-1:0]    r_lock_id;
  logic [LK_W-1:0]    r_lock_idle;
  logic [NUM_REQ-1:0] w_lock_onehot;
  logic               w_lock_valid;

  always_comb begin
    w_lock_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (r_lock_id == ID_W'(i)) w_lock_onehot[i] = 1'b1;
    end
  end

  assign w_lock_valid = |(req_valid & w_lock_onehot);
  assign w_req_eff    = r_locked ? (req_valid & w_lock_onehot) : req_valid;

  // An LF from the owner ends its line; a silent owner loses the lock after LOCK_IDLE cycles.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_locked    <= 1'b0;
      r_lock_id   <= '0;
      r_lock_idle <= '0;
    end else if (w_accept) begin
      r_locked    <= (w_sel_data != ASCII_LF);
      r_lock_id   <= w_win;
      r_lock_idle <= '0;
    end else if (r_locked) begin
      if (w_lock_valid) begin
        r_lock_idle <= '0;
      end else if (r_lock_idle == LK_LAST) begin
        r_locked    <= 1'b0;
        r_lock_idle <= '0;
      end else begin
        r_lock_idle <= r_lock_idle + LK_W'(1);
      end
    end
  end
`else
  logic w_unused_lock_idle;

  assign w_unused_lock_idle = (LOCK_IDLE == 0);
  assign w_req_eff          = req_valid;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_tx_en_nxt   = r_tx_en;
    w_tx_data_nxt = r_tx_data;
    w_ready_nxt   = '0;
    w_grant_nxt   = r_grant;
    w_timeout_nxt = 1'b0;
    w_accept      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (!uart_tx_busy && w_any) begin
          w_accept      = 1'b1;
          w_tx_data_nxt = w_sel_data;
          w_tx_en_nxt   = 1'b1;
          w_ready_nxt   = w_win_onehot;
          w_grant_nxt   = w_win;
          w_ptr_nxt     = w_win;
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_START;
        end
      end
      ST_START: begin
        if (uart_tx_busy) begin
          w_tx_en_nxt = 1'b0;
          w_state_nxt = ST_DRAIN;
        end else if (r_cnt == CNT_LAST) begin
          w_tx_en_nxt   = 1'b0;
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (!uart_tx_busy) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= PTR_RST;
      r_cnt     <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      r_ready   <= '0;
      r_grant   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_tx_en   <= w_tx_en_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_ready   <= w_ready_nxt;
      r_grant   <= w_grant_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign req_ready    = r_ready;
  assign uart_tx_en   = r_tx_en;
  assign uart_tx_data = r_tx_data;
  assign grant_id     = r_grant;
  assign arb_busy     = (r_state != ST_IDLE);
  assign tx_timeout   = r_timeout;

endmodule
